// File: rtl/sdram_scheduler.sv
`timescale 1ns/1ps
// sdram_scheduler: queues read/write requests in a first-word fall-through
// FIFO, runs the SDRAM power-up sequence, then issues ACTIVATE / READ / WRITE /
// PRECHARGE_ALL / AREFRESH commands to a downstream command-level driver while
// keeping periodic refresh on schedule.
// Optional feature macro: SDRAM_SCHED_KEEP_OPEN_EN (honour keep_open so an
// empty queue leaves the row open instead of closing and refreshing).
module sdram_scheduler #(
  parameter int unsigned CLOCK_PERIOD_NS     = 8,
  parameter int unsigned FIFO_DEPTH          = 16,
  parameter int unsigned BOOT_WAIT_NS        = 100000,
  parameter int unsigned REFRESH_INTERVAL_NS = 7812,
  parameter int unsigned REFRESH_GUARD       = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_write,
  input  logic                          req_is_write,
  input  logic [24:0]                   req_addr,
  input  logic [1:0]                    req_mask,
  input  logic [15:0]                   req_wdata,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_usage,
  input  logic                          keep_open,
  input  logic                          command_ready,
  input  logic                          precharge_ready,
  input  logic                          write_ready,
  input  logic                          row_open,
  output logic [3:0]                    cmd,
  output logic [12:0]                   cmd_addr,
  output logic [1:0]                    cmd_bank,
  output logic [1:0]                    cmd_mask,
  output logic [15:0]                   cmd_wdata,
  output logic                          busy,
  output logic [15:0]                   refresh_countdown
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BOOT_CYCLES =
    (BOOT_WAIT_NS + CLOCK_PERIOD_NS - 1) / CLOCK_PERIOD_NS + 10;
  localparam logic [31:0]      BOOT_LAST    = 32'(BOOT_CYCLES - 1);
  localparam logic [15:0]      REFRESH_LOAD = 16'(REFRESH_INTERVAL_NS / CLOCK_PERIOD_NS);
  localparam logic [15:0]      GUARD_C      = 16'(REFRESH_GUARD);
  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    CMD_NOOP          = 4'd0,
    CMD_ACTIVATE      = 4'd1,
    CMD_READ          = 4'd2,
    CMD_WRITE         = 4'd3,
    CMD_PRECHARGE_ALL = 4'd6,
    CMD_AREFRESH      = 4'd7,
    CMD_SET_MODE_REG  = 4'd8
  } cmd_e;

  typedef enum logic [3:0] {
    S_BOOT_WAIT,
    S_BOOT_PRE,
    S_BOOT_MODE,
    S_BOOT_REF1,
    S_BOOT_REF2,
    S_IDLE,
    S_OPEN,
    S_CLOSE,
    S_REFRESH
  } state_e;

  // FIFO entry layout: {is_write, addr[24:0], mask[1:0], wdata[15:0]}
  logic [43:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_usage;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_boot_cnt;
  logic [15:0] r_refresh_cnt;
  logic [1:0]  r_open_bank;
  logic [12:0] r_open_row;

  cmd_e        w_cmd;
  logic [12:0] w_cmd_addr;
  logic [1:0]  w_cmd_bank;
  logic [1:0]  w_cmd_mask;
  logic [15:0] w_cmd_wdata;
  logic        w_busy;
  logic        w_pop;
  logic        w_push;
  logic        w_latch;
  logic        w_full;
  logic        w_empty;
  logic        w_keep_open;
  logic        w_refresh_due;
  logic        w_hit;
  logic        w_close_row;

  logic [43:0] w_head;
  logic        w_head_is_write;
  logic [1:0]  w_head_bank;
  logic [12:0] w_head_row;
  logic [9:0]  w_head_col;
  logic [1:0]  w_head_mask;
  logic [15:0] w_head_wdata;

`ifdef SDRAM_SCHED_KEEP_OPEN_EN
  assign w_keep_open = keep_open;
`else
  assign w_keep_open = keep_open & 1'b0;
`endif

  assign w_full  = (r_usage == DEPTH_C);
  assign w_empty = (r_usage == '0);
  assign w_push  = req_write & ~w_full;

  assign w_head          = r_mem[r_rd_ptr];
  assign w_head_is_write = w_head[43];
  assign w_head_bank     = w_head[42:41];
  assign w_head_row      = w_head[40:28];
  assign w_head_col      = w_head[27:18];
  assign w_head_mask     = w_head[17:16];
  assign w_head_wdata    = w_head[15:0];

  assign w_refresh_due = (r_refresh_cnt <= GUARD_C);
  assign w_hit         = ~w_empty & ({w_head_bank, w_head_row} == {r_open_bank, r_open_row});
  assign w_close_row   = w_refresh_due | (~w_empty & ~w_hit) | (w_empty & ~w_keep_open);

  // Queue storage; not reset because usage/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_is_write, req_addr, req_mask, req_wdata};
    end
  end

  // Queue pointers and occupancy; a dropped write (full) never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_usage <= r_usage + CNT_W'(1);
        2'b01:   r_usage <= r_usage - CNT_W'(1);
        default: r_usage <= r_usage;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BOOT_WAIT;
    else        r_state <= w_state_next;
  end

  // Power-up wait counter, cleared whenever the FSM is not waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_boot_cnt <= '0;
    else if (r_state == S_BOOT_WAIT) r_boot_cnt <= r_boot_cnt + 32'd1;
    else                           r_boot_cnt <= '0;
  end

  // Refresh countdown: reload on each issued AREFRESH, else count down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_refresh_cnt <= '0;
    else if (w_cmd == CMD_AREFRESH) r_refresh_cnt <= REFRESH_LOAD;
    else if (r_refresh_cnt != '0)   r_refresh_cnt <= r_refresh_cnt - 16'd1;
  end

  // Bank/row opened by the last ACTIVATE, used for hit detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open_bank <= '0;
      r_open_row  <= '0;
    end else if (w_latch) begin
      r_open_bank <= w_head_bank;
      r_open_row  <= w_head_row;
    end
  end

  // Next-state and command decode.
  always_comb begin
    w_state_next = r_state;
    w_cmd        = CMD_NOOP;
    w_cmd_addr   = '0;
    w_cmd_bank   = '0;
    w_cmd_mask   = '0;
    w_cmd_wdata  = '0;
    w_busy       = 1'b0;
    w_pop        = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      S_BOOT_WAIT: begin
        w_busy = 1'b1;
        if (r_boot_cnt == BOOT_LAST) w_state_next = S_BOOT_PRE;
      end
      S_BOOT_PRE: begin
        w_busy = 1'b1;
        if (command_ready) begin
          w_cmd        = CMD_PRECHARGE_ALL;
          w_state_next = S_BOOT_MODE;
        end
      end
      S_BOOT_MODE: begin
        w_busy = 1'b1;
        if (command_ready) begin
          w_cmd        = CMD_SET_MODE_REG;
          w_state_next = S_BOOT_REF1;
        end
      end
      S_BOOT_REF1: begin
        w_busy = 1'b1;
        if (command_ready) begin
          w_cmd        = CMD_AREFRESH;
          w_state_next = S_BOOT_REF2;
        end
      end
      S_BOOT_REF2: begin
        w_busy = 1'b1;
        if (command_ready) begin
          w_cmd        = CMD_AREFRESH;
          w_state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_refresh_due || (w_empty && !w_keep_open)) begin
          if (command_ready) w_cmd  = CMD_AREFRESH;
          else               w_busy = 1'b1;
        end else if (!w_empty) begin
          if (command_ready) begin
            w_cmd        = CMD_ACTIVATE;
            w_cmd_bank   = w_head_bank;
            w_cmd_addr   = w_head_row;
            w_latch      = 1'b1;
            w_state_next = S_OPEN;
          end else begin
            w_busy = 1'b1;
          end
        end
      end
      S_OPEN: begin
        if (w_close_row) begin
          w_state_next = S_CLOSE;
        end else if (!w_empty) begin
          if (!command_ready) begin
            w_busy = 1'b1;
          end else if (row_open && (!w_head_is_write || write_ready)) begin
            w_cmd       = w_head_is_write ? CMD_WRITE : CMD_READ;
            w_cmd_addr  = {3'b000, w_head_col};
            w_cmd_bank  = r_open_bank;
            w_cmd_mask  = w_head_mask;
            w_cmd_wdata = w_head_wdata;
            w_pop       = 1'b1;
          end
        end
      end
      S_CLOSE: begin
        w_busy = 1'b1;
        if (command_ready && precharge_ready) begin
          w_cmd        = CMD_PRECHARGE_ALL;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_BOOT_WAIT;
      end
    endcase
  end

  assign full              = w_full;
  assign fifo_usage        = r_usage;
  assign cmd               = w_cmd;
  assign cmd_addr          = w_cmd_addr;
  assign cmd_bank          = w_cmd_bank;
  assign cmd_mask          = w_cmd_mask;
  assign cmd_wdata         = w_cmd_wdata;
  assign busy              = w_busy;
  assign refresh_countdown = r_refresh_cnt;

endmodule

// File: tb/tb_sdram_scheduler.sv
`timescale 1ns/1ps
// Directed self-checking bench for sdram_scheduler (default parameters).
module tb_sdram_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_write;
  logic        req_is_write;
  logic [24:0] req_addr;
  logic [1:0]  req_mask;
  logic [15:0] req_wdata;
  logic        full;
  logic [4:0]  fifo_usage;
  logic        keep_open;
  logic        command_ready;
  logic        precharge_ready;
  logic        write_ready;
  logic        row_open;
  logic [3:0]  cmd;
  logic [12:0] cmd_addr;
  logic [1:0]  cmd_bank;
  logic [1:0]  cmd_mask;
  logic [15:0] cmd_wdata;
  logic        busy;
  logic [15:0] refresh_countdown;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  sdram_scheduler #(
    .CLOCK_PERIOD_NS    (8),
    .FIFO_DEPTH         (16),
    .BOOT_WAIT_NS       (100000),
    .REFRESH_INTERVAL_NS(7812),
    .REFRESH_GUARD      (12)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_write        (req_write),
    .req_is_write     (req_is_write),
    .req_addr         (req_addr),
    .req_mask         (req_mask),
    .req_wdata        (req_wdata),
    .full             (full),
    .fifo_usage       (fifo_usage),
    .keep_open        (keep_open),
    .command_ready    (command_ready),
    .precharge_ready  (precharge_ready),
    .write_ready      (write_ready),
    .row_open         (row_open),
    .cmd              (cmd),
    .cmd_addr         (cmd_addr),
    .cmd_bank         (cmd_bank),
    .cmd_mask         (cmd_mask),
    .cmd_wdata        (cmd_wdata),
    .busy             (busy),
    .refresh_countdown(refresh_countdown)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic is_w, input logic [24:0] addr,
                          input logic [1:0] mask, input logic [15:0] data);
    req_write    = 1'b1;
    req_is_write = is_w;
    req_addr     = addr;
    req_mask     = mask;
    req_wdata    = data;
  endtask

  // Holds rst_n low for 3 clocks (it must already be low), releases it and
  // follows the power-up sequence into IDLE.
  task automatic boot_check();
    int unsigned n;
    logic        busy_all;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n        = 0;
    busy_all = 1'b1;
    @(negedge clk);
    while (cmd == 4'd0 && n < 20000) begin
      if (!busy) busy_all = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("boot_wait_cycles", n, 12510);
    chk("boot_wait_busy", busy_all, 1);
    chk("boot_pre_cmd", cmd, 6);
    chk("boot_pre_busy", busy, 1);
    @(negedge clk);
    chk("boot_mode_cmd", cmd, 8);
    @(negedge clk);
    chk("boot_ref1_cmd", cmd, 7);
    @(negedge clk);
    chk("boot_ref2_cmd", cmd, 7);
    @(negedge clk);
    chk("boot_countdown", refresh_countdown, 976);
    chk("idle_empty_refresh", cmd, 7);
    chk("idle_busy", busy, 0);
    chk("idle_usage", fifo_usage, 0);
  endtask

  initial begin
    int unsigned n;
    logic        saw_cmd;

    rst_n           = 1'b0;
    req_write       = 1'b0;
    req_is_write    = 1'b0;
    req_addr        = '0;
    req_mask        = '0;
    req_wdata       = '0;
    keep_open       = 1'b0;
    command_ready   = 1'b1;
    precharge_ready = 1'b1;
    write_ready     = 1'b1;
    row_open        = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd", cmd, 0);
    chk("rst_busy", busy, 1);
    chk("rst_usage", fifo_usage, 0);
    chk("rst_full", full, 0);
    chk("rst_countdown", refresh_countdown, 0);
    boot_check();

    // Write then read same address
    push_req(1'b1, 25'h0000400, 2'b11, 16'hBEEF);
    @(negedge clk);
    chk("wr_act_cmd", cmd, 1);
    chk("wr_act_bank", cmd_bank, 0);
    chk("wr_act_row", cmd_addr, 1);
    chk("wr_usage1", fifo_usage, 1);
    push_req(1'b0, 25'h0000400, 2'b00, 16'h0000);
    @(negedge clk);
    req_write = 1'b0;
    chk("wr_usage2", fifo_usage, 2);
    chk("wr_cmd", cmd, 3);
    chk("wr_col", cmd_addr, 0);
    chk("wr_wdata", cmd_wdata, 16'hBEEF);
    chk("wr_mask", cmd_mask, 2'b11);
    @(negedge clk);
    chk("rd_cmd", cmd, 2);
    chk("rd_col", cmd_addr, 0);
    chk("rd_usage1", fifo_usage, 1);
    @(negedge clk);
    chk("rd_usage0", fifo_usage, 0);
    chk("empty_open_noop", cmd, 0);
    @(negedge clk);
    chk("close_pre", cmd, 6);
    chk("close_busy", busy, 1);
    @(negedge clk);
    chk("close_ref", cmd, 7);

    // Row miss: row 1 then row 2, precharge held off
    precharge_ready = 1'b0;
    push_req(1'b0, 25'h0000400, 2'b00, 16'h0000);
    @(negedge clk);
    chk("miss_act1", cmd, 1);
    chk("miss_act1_row", cmd_addr, 1);
    push_req(1'b0, 25'h0000800, 2'b00, 16'h0000);
    @(negedge clk);
    req_write = 1'b0;
    chk("miss_rd1", cmd, 2);
    chk("miss_usage2", fifo_usage, 2);
    @(negedge clk);
    chk("miss_noop", cmd, 0);
    @(negedge clk);
    chk("miss_pre_held", cmd, 0);
    chk("miss_close_busy", busy, 1);
    @(negedge clk);
    chk("miss_pre_held2", cmd, 0);
    precharge_ready = 1'b1;
    #1 chk("miss_pre", cmd, 6);
    @(negedge clk);
    chk("miss_act2", cmd, 1);
    chk("miss_act2_row", cmd_addr, 2);
    @(negedge clk);
    chk("miss_rd2", cmd, 2);
    @(negedge clk);
    chk("miss_end_noop", cmd, 0);
    @(negedge clk);
    chk("miss_end_pre", cmd, 6);
    @(negedge clk);
    chk("miss_end_ref", cmd, 7);

    // Overflow: 17 writes with command_ready low
    command_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push_req(1'b1, {2'b00, 13'd1, 10'(i)}, 2'b01, 16'(16'hA000 + i));
      @(negedge clk);
      chk("fill_usage", fifo_usage, (i >= 15) ? 16 : i + 1);
      chk("fill_full", full, (i >= 15) ? 1 : 0);
    end
    req_write = 1'b0;
    chk("fill_blocked_busy", busy, 1);
    chk("fill_blocked_cmd", cmd, 0);
    command_ready = 1'b1;
    #1 chk("drain_act", cmd, 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("drain_cmd", cmd, 3);
      chk("drain_wdata", cmd_wdata, 16'hA000 + k);
      chk("drain_col", cmd_addr, k);
    end
    @(negedge clk);
    chk("drain_empty_usage", fifo_usage, 0);
    chk("drain_empty_noop", cmd, 0);
    @(negedge clk);
    chk("drain_pre", cmd, 6);
    @(negedge clk);
    chk("drain_ref", cmd, 7);

    // Refresh guard with a stalled write at the head
    write_ready = 1'b0;
    push_req(1'b1, 25'h0000400, 2'b10, 16'h1234);
    @(negedge clk);
    req_write = 1'b0;
    chk("guard_act", cmd, 1);
    chk("guard_reload", refresh_countdown, 976);
    n       = 0;
    saw_cmd = 1'b0;
    @(negedge clk);
    while (refresh_countdown != 16'd12 && n < 2000) begin
      if (cmd != 4'd0) saw_cmd = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("guard_reached", refresh_countdown, 12);
    chk("guard_cycles", n, 963);
    chk("guard_no_cmd", saw_cmd, 0);
    write_ready = 1'b1;
    #1 chk("guard_no_access", cmd, 0);
    @(negedge clk);
    chk("guard_pre", cmd, 6);
    @(negedge clk);
    chk("guard_ref", cmd, 7);
    chk("guard_count10", refresh_countdown, 10);
    @(negedge clk);
    chk("guard_after_reload", refresh_countdown, 976);
    chk("guard_react", cmd, 1);
    @(negedge clk);
    chk("guard_wr", cmd, 3);
    chk("guard_wr_data", cmd_wdata, 16'h1234);
    chk("guard_wr_mask", cmd_mask, 2'b10);
    @(negedge clk);
    chk("guard_end_noop", cmd, 0);
    @(negedge clk);
    chk("guard_end_pre", cmd, 6);
    @(negedge clk);
    chk("guard_end_ref", cmd, 7);

    // keep_open with an empty queue
    keep_open = 1'b1;
    push_req(1'b0, 25'h0000400, 2'b00, 16'h0000);
    @(negedge clk);
    req_write = 1'b0;
    chk("keep_act", cmd, 1);
    @(negedge clk);
    chk("keep_rd", cmd, 2);
    @(negedge clk);
    chk("keep_empty_noop", cmd, 0);
    @(negedge clk);
`ifdef SDRAM_SCHED_KEEP_OPEN_EN
    chk("keep_hold1", cmd, 0);
    @(negedge clk);
    chk("keep_hold2", cmd, 0);
    keep_open = 1'b0;
    @(negedge clk);
    chk("keep_release_noop", cmd, 0);
    @(negedge clk);
    chk("keep_release_pre", cmd, 6);
    @(negedge clk);
    chk("keep_release_ref", cmd, 7);
`else
    chk("keep_ignored_pre", cmd, 6);
    @(negedge clk);
    chk("keep_ignored_ref", cmd, 7);
    keep_open = 1'b0;
`endif

    // Asynchronous reset mid-operation with queued requests
    command_ready = 1'b0;
    push_req(1'b0, {2'b10, 13'd5, 10'd3}, 2'b00, 16'h0000);
    @(negedge clk);
    push_req(1'b1, {2'b10, 13'd5, 10'd4}, 2'b01, 16'h5555);
    @(negedge clk);
    req_write = 1'b0;
    chk("mid_usage2", fifo_usage, 2);
    command_ready = 1'b1;
    #1 chk("mid_act", cmd, 1);
    chk("mid_act_bank", cmd_bank, 2);
    chk("mid_act_row", cmd_addr, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", cmd, 0);
    chk("mid_rst_bank", cmd_bank, 0);
    chk("mid_rst_addr", cmd_addr, 0);
    chk("mid_rst_usage", fifo_usage, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_countdown", refresh_countdown, 0);
    chk("mid_rst_busy", busy, 1);
    boot_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
